// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
//   Bundle between the pipeline datapath and the hazard/stall sequencer.
//   master : pipeline side. It drives the hazard sources and receives the
//            stage enables and flushes.
//   slave  : sequencer side (hazard_stall_ctrl).
//   Hazard sources : id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead,
//                    ex_rd, ex_branch_taken, mem_req, mem_ready
//   Stage controls : pc_write, if_id_write, if_id_flush, id_ex_write,
//                    id_ex_flush, ex_mem_write, mem_wb_flush, mem_timeout
//   HAZARD_PERF_CNT_EN : when defined, adds the CNT_W parameter and the
//                        stall_cycles / flush_cycles counters.
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_memRead;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_flush;
  logic       ex_mem_write;
  logic       mem_wb_flush;
  logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;
`endif

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles, flush_cycles
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles, flush_cycles
`endif
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It resolves three
//   kinds of event:
//   - data-memory waits, which hold the whole front of the pipe
//   - taken-branch redirects, which flush IF_ID and ID_EX
//   - load-use hazards, which insert one bubble into ID_EX
//   If a memory wait runs too long, the sequencer raises a sticky timeout
//   fault.
//   Ports:
//     clk : pipeline clock
//     rst : synchronous, active-high reset. While rst is high, every stage
//           enable is forced low and every flush is forced high.
//     bus : hazard_stall_ctrl_if.slave (hazard sources in, stage controls out)
//   Parameters:
//     MEM_TIMEOUT : the maximum number of consecutive MEM wait cycles before
//                   the fault is raised (>= 2)
//     CNT_W       : the width of the performance counters (HAZARD_PERF_CNT_EN
//                   builds only)
//   HAZARD_PERF_CNT_EN : when defined, adds the saturating stall_cycles and
//                        flush_cycles counters.
//   The stage controls are combinational from the state and the inputs.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic               clk,
  input logic               rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST_C = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] wait_cnt_r;
  logic [CW-1:0] wait_cnt_nxt_s;
  logic          mem_timeout_r;
  logic          mem_timeout_nxt_s;

  logic mem_wait_s;
  logic load_use_s;
  logic redirect_s;
  logic pc_write_s;
  logic if_id_write_s;
  logic if_id_flush_s;
  logic id_ex_write_s;
  logic id_ex_flush_s;
  logic ex_mem_write_s;
  logic mem_wb_flush_s;

  assign mem_wait_s = bus.mem_req & ~bus.mem_ready;

  // A load that writes x0 never creates a hazard, so rd == 0 is excluded.
  assign load_use_s = bus.ex_memRead & (bus.ex_rd != 5'd0) &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // A redirect is effective only when nothing with a higher priority owns the cycle.
  assign redirect_s = ~rst & (state_r != ST_FAULT) & ~mem_wait_s & bus.ex_branch_taken;

  // State register: FSM state, wait counter and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= CNT_ZERO_C;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      mem_timeout_r <= mem_timeout_nxt_s;
    end
  end

  // Next-state logic: track consecutive memory-wait cycles and detect the timeout.
  always_comb begin
    state_nxt_s       = state_r;
    wait_cnt_nxt_s    = wait_cnt_r;
    mem_timeout_nxt_s = mem_timeout_r;
    case (state_r)
      ST_RUN: begin
        if (mem_wait_s) begin
          state_nxt_s    = ST_WAIT;
          wait_cnt_nxt_s = CNT_ONE_C;
        end else begin
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = CNT_ZERO_C;
        end
      end
      ST_WAIT: begin
        if (mem_wait_s) begin
          if (wait_cnt_r == CNT_LAST_C) begin
            state_nxt_s       = ST_FAULT;
            mem_timeout_nxt_s = 1'b1;
          end else begin
            state_nxt_s    = ST_WAIT;
            wait_cnt_nxt_s = wait_cnt_r + CNT_ONE_C;
          end
        end else begin
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = CNT_ZERO_C;
        end
      end
      ST_FAULT: begin
        state_nxt_s       = ST_FAULT;
        mem_timeout_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s    = ST_RUN;
        wait_cnt_nxt_s = CNT_ZERO_C;
      end
    endcase
  end

  // Output logic, in priority order: reset/fault, mem wait, redirect, load-use.
  // RUN and WAIT share one decode, because a released wait behaves like RUN.
  always_comb begin
    pc_write_s     = 1'b1;
    if_id_write_s  = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_write_s  = 1'b1;
    id_ex_flush_s  = 1'b0;
    ex_mem_write_s = 1'b1;
    mem_wb_flush_s = 1'b0;
    if (rst || (state_r == ST_FAULT)) begin
      pc_write_s     = 1'b0;
      if_id_write_s  = 1'b0;
      if_id_flush_s  = 1'b1;
      id_ex_write_s  = 1'b0;
      id_ex_flush_s  = 1'b1;
      ex_mem_write_s = 1'b0;
      mem_wb_flush_s = 1'b1;
    end else if (mem_wait_s) begin
      // Hold PC..EX_MEM so that EX is re-evaluated when the access completes.
      pc_write_s     = 1'b0;
      if_id_write_s  = 1'b0;
      id_ex_write_s  = 1'b0;
      ex_mem_write_s = 1'b0;
      mem_wb_flush_s = 1'b1;
    end else if (bus.ex_branch_taken) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (load_use_s) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_ex_flush_s = 1'b1;
    end else begin
      pc_write_s = 1'b1;
    end
  end

  assign bus.pc_write     = pc_write_s;
  assign bus.if_id_write  = if_id_write_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_write  = id_ex_write_s;
  assign bus.id_ex_flush  = id_ex_flush_s;
  assign bus.ex_mem_write = ex_mem_write_s;
  assign bus.mem_wb_flush = mem_wb_flush_s;
  assign bus.mem_timeout  = mem_timeout_r;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] PERF_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PERF_ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_cycles_r;

  // Performance counters: saturating, and frozen once the fault is latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r <= {CNT_W{1'b0}};
      flush_cycles_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_FAULT) begin
      if (!pc_write_s && (stall_cycles_r != PERF_MAX_C)) begin
        stall_cycles_r <= stall_cycles_r + PERF_ONE_C;
      end
      if (redirect_s && (flush_cycles_r != PERF_MAX_C)) begin
        flush_cycles_r <= flush_cycles_r + PERF_ONE_C;
      end
    end
  end

  assign bus.stall_cycles = stall_cycles_r;
  assign bus.flush_cycles = flush_cycles_r;
`else
  // Without counters, the redirect qualifier has no consumer.
  logic unused_s;
  assign unused_s = redirect_s;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus();
  hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model state: a fault flag and a count of consecutive wait cycles.
  bit m_valid = 1'b0;
  bit m_fault = 1'b0;
  bit m_to    = 1'b0;
  int m_wait  = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
`endif

  logic [7:0] dut_vec;
  assign dut_vec = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                    bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush, bus.mem_timeout};

  // The result is packed as {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f, timeout}.
  function automatic logic [7:0] exp_vec();
    bit lu;
    lu = bus.ex_memRead && (bus.ex_rd != 5'd0) &&
         ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
          (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    if (rst || m_fault)                    return {7'b0000111, m_to};
    else if (bus.mem_req && !bus.mem_ready) return {7'b0000001, m_to};
    else if (bus.ex_branch_taken)          return {7'b1111110, m_to};
    else if (lu)                           return {7'b0011010, m_to};
    else                                   return {7'b1111000, m_to};
  endfunction

  // The model advances on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_fault <= 1'b0;
      m_to    <= 1'b0;
      m_wait  <= 0;
`ifdef HAZARD_PERF_CNT_EN
      m_stall <= 32'd0;
      m_flush <= 32'd0;
`endif
    end else if (!m_fault) begin
`ifdef HAZARD_PERF_CNT_EN
      if (!exp_vec() [7] && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 32'd1;
      if (!(bus.mem_req && !bus.mem_ready) && bus.ex_branch_taken && m_flush != 32'hFFFF_FFFF)
        m_flush <= m_flush + 32'd1;
`endif
      if (bus.mem_req && !bus.mem_ready) begin
        m_wait <= m_wait + 1;
        if (m_wait + 1 == MEM_TIMEOUT) begin
          m_fault <= 1'b1;
          m_to    <= 1'b1;
        end
      end else begin
        m_wait <= 0;
      end
    end
  end

  // Every cycle, the compare process checks the DUT against the model on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL model_cmp t=%0t got=%b want=%b", $time, dut_vec, exp_vec());
      end
`ifdef HAZARD_PERF_CNT_EN
      total++;
      if (bus.stall_cycles !== m_stall || bus.flush_cycles !== m_flush) begin
        bad++;
        $display("FAIL perf_cmp t=%0t got=%0d/%0d want=%0d/%0d", $time,
                 bus.stall_cycles, bus.flush_cycles, m_stall, m_flush);
      end
`endif
    end
  end

  task automatic check_lit(input string name, input logic [7:0] want);
    total++;
    if (dut_vec !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, dut_vec, want);
    end
  endtask

  task automatic idle();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_memRead = 1'b0; bus.ex_rd = 5'd0; bus.ex_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    bus.id_rs1 = 5'($urandom_range(0, 3));
    bus.id_rs2 = 5'($urandom_range(0, 3));
    bus.id_use_rs1 = 1'($urandom_range(0, 1));
    bus.id_use_rs2 = 1'($urandom_range(0, 1));
    bus.ex_memRead = 1'($urandom_range(0, 1));
    bus.ex_rd = 5'($urandom_range(0, 3));
    bus.ex_branch_taken = ($urandom_range(0, 4) == 0);
    bus.mem_req = 1'($urandom_range(0, 1));
    bus.mem_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Reset: two cycles, then normal.
    @(negedge clk); check_lit("rst_c1", 8'b0000_1110);
    next_cycle(); @(negedge clk); check_lit("rst_c2", 8'b0000_1110);
    next_cycle(); rst = 1'b0; @(negedge clk); check_lit("run_idle", 8'b1111_0000);
    // Load-use on rs2.
    next_cycle(); bus.ex_memRead = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
    @(negedge clk); check_lit("load_use_rs2", 8'b0011_0100);
    next_cycle(); idle(); @(negedge clk); check_lit("load_use_release", 8'b1111_0000);
    // A load to x0 never stalls.
    next_cycle(); bus.ex_memRead = 1'b1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0; bus.id_use_rs2 = 1'b1;
    @(negedge clk); check_lit("rd_x0", 8'b1111_0000);
    // Load-use on rs1; the matching rs2 is unused.
    next_cycle(); idle(); bus.ex_memRead = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1'b1;
    bus.id_rs2 = 5'd7;
    @(negedge clk); check_lit("load_use_rs1", 8'b0011_0100);
    next_cycle(); bus.id_use_rs1 = 1'b0; bus.id_rs1 = 5'd3;
    @(negedge clk); check_lit("use_gate", 8'b1111_0000);
    // A redirect beats a same-cycle load-use.
    next_cycle(); bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd7; bus.ex_branch_taken = 1'b1;
    @(negedge clk); check_lit("redirect_over_lu", 8'b1111_1100);
    // Three wait cycles, then ready. A branch during the wait is ignored.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.ex_branch_taken = (i == 1);
      @(negedge clk); check_lit("mem_wait", 8'b0000_0010);
    end
    next_cycle(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk); check_lit("mem_release", 8'b1111_0000);
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (bus.stall_cycles !== 32'd5 || bus.flush_cycles !== 32'd1) begin
      bad++;
      $display("FAIL perf_lit got=%0d/%0d want=5/1", bus.stall_cycles, bus.flush_cycles);
    end
`endif
    // Random phase with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst = ($urandom_range(0, 99) == 0);
      rand_inputs();
    end
    // Timeout: 16 wait cycles, then a fault that persists until reset.
    next_cycle(); rst = 1'b1; idle();
    next_cycle(); rst = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      next_cycle(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      @(negedge clk); check_lit("timeout_wait", 8'b0000_0010);
    end
    next_cycle(); idle(); bus.mem_req = 1'b1; bus.mem_ready = 1'b1; bus.ex_branch_taken = 1'b1;
    @(negedge clk); check_lit("fault_entry", 8'b0000_1111);
    for (int i = 0; i < 5; i++) begin
      next_cycle(); rand_inputs();
      @(negedge clk); check_lit("fault_hold", 8'b0000_1111);
    end
    next_cycle(); rst = 1'b1; @(negedge clk); check_lit("fault_rst", 8'b0000_1111);
    next_cycle(); rst = 1'b0; idle(); @(negedge clk); check_lit("post_fault_run", 8'b1111_0000);
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
